queue_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream queue enqueue port among N requesters (for example several issue or writeback sources feeding one queue).
- Selects one valid requester per cycle and forwards its data on a decoupled output.
- Holds the grant while a transfer is stalled, so the output never changes while it is valid and not yet accepted.
- Supports bounded bursts per requester and a synchronous flush that shares semantics with the queue it feeds.

---
 rtl/queue_rr_arbiter_pkg.sv | 16 +
 rtl/queue_rr_arbiter_rr_pick.sv | 32 +++
 rtl/queue_rr_arbiter.sv | 103 ++++++++++
 tb/tb_queue_rr_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/queue_rr_arbiter_pkg.sv
// queue_rr_arbiter_pkg: shared types and helpers for the queue round-robin arbiter.
//   gpreg_t    : default payload carried by requesters and the dequeue side
//   arb_idx_t  : requester index for the default requester count
//   next_idx() : wrapping increment of a requester index
package queue_rr_arbiter_pkg;

    localparam int ARB_N = 4;

    typedef logic [63:0] gpreg_t;
    typedef logic [$clog2(ARB_N)-1:0] arb_idx_t;

    function automatic int next_idx(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/queue_rr_arbiter_rr_pick.sv
// queue_rr_arbiter_rr_pick: combinational priority picker starting at ptr.
//   valid : per-requester request vector
//   ptr   : index holding highest priority
//   idx   : first valid index scanning ptr, ptr+1, ... modulo N (0 when none)
//   any   : at least one request is valid
module queue_rr_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = IW'((int'(ptr) + k) % N);
            if (valid[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/queue_rr_arbiter.sv
// queue_rr_arbiter: shares one queue enqueue port among N requesters, round-robin
// with bounded bursts and a held grant while the downstream stalls.
//   clk, rst (async, active-high), flush (sync clear of arbitration state)
//   req_valid/req_ready/req_data : N decoupled requesters
//   deq_valid/deq_ready/deq_data : arbitrated output toward a queue enq port
//   grant_idx    : currently selected requester
//   grant_active : a grant is presented (same as deq_valid)
module queue_rr_arbiter
    import queue_rr_arbiter_pkg::*;
#(
    parameter type Data  = gpreg_t,
    parameter int  N     = ARB_N,
    parameter int  BURST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  Data                  req_data [N],
    output logic                 deq_valid,
    input  logic                 deq_ready,
    output Data                  deq_data,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_active
);

    localparam int IW = $clog2(N);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    logic [IW-1:0] ptr, lock_idx, last_idx;
    logic          locked;
    logic [BW-1:0] burst_cnt;

    logic [IW-1:0] ptr_n, lock_idx_n, last_idx_n;
    logic          locked_n;
    logic [BW-1:0] burst_cnt_n;

    logic [IW-1:0] pick_idx, sel;
    logic          pick_any, xfer;
    logic [BW-1:0] cnt_eff;

    queue_rr_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A held lock pins the selection so data never changes while stalled.
    assign sel          = locked ? lock_idx : pick_idx;
    assign deq_valid    = locked ? req_valid[lock_idx] : pick_any;
    assign deq_data     = req_data[sel];
    assign grant_idx    = sel;
    assign grant_active = deq_valid;
    assign xfer         = deq_valid && deq_ready;

    // A burst only continues while the same index keeps winning.
    assign cnt_eff = (sel == last_idx) ? burst_cnt : '0;

    always_comb begin
        req_ready      = '0;
        req_ready[sel] = xfer;
    end

    always_comb begin
        ptr_n       = ptr;
        lock_idx_n  = lock_idx;
        last_idx_n  = last_idx;
        burst_cnt_n = burst_cnt;
        locked_n    = 1'b0;
        if (deq_valid && !deq_ready) begin
            locked_n   = 1'b1;
            lock_idx_n = sel;
        end else if (xfer) begin
            last_idx_n = sel;
            if (cnt_eff == BW'(BURST - 1)) begin
                burst_cnt_n = '0;
                ptr_n       = IW'(next_idx(int'(sel), N));
            end else begin
                burst_cnt_n = cnt_eff + 1'b1;
                ptr_n       = sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            ptr       <= '0;
            locked    <= 1'b0;
            lock_idx  <= '0;
            last_idx  <= '0;
            burst_cnt <= '0;
        end else begin
            ptr       <= ptr_n;
            locked    <= locked_n;
            lock_idx  <= lock_idx_n;
            last_idx  <= last_idx_n;
            burst_cnt <= burst_cnt_n;
        end
    end

endmodule

// File: tb/tb_queue_rr_arbiter.sv
// tb_queue_rr_arbiter: directed scoreboard bench for BURST=1 and BURST=3 arbiters.
module tb_queue_rr_arbiter;
    import queue_rr_arbiter_pkg::*;

    typedef struct {
        string    tag;
        int       d;
        logic     v;
        arb_idx_t idx;
        logic [3:0] rdy;
        gpreg_t   data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, flush, deq_ready;
    logic [3:0] req_valid;
    gpreg_t     req_data [4];
    gpreg_t     base;

    logic [3:0] rdy1, rdy3;
    logic       dv1, dv3, ga1, ga3;
    gpreg_t     dd1, dd3;
    arb_idx_t   gi1, gi3;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    queue_rr_arbiter #(.N(4), .BURST(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(rdy1),
        .req_data(req_data), .deq_valid(dv1), .deq_ready(deq_ready), .deq_data(dd1),
        .grant_idx(gi1), .grant_active(ga1)
    );

    queue_rr_arbiter #(.N(4), .BURST(3)) u3 (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(rdy3),
        .req_data(req_data), .deq_valid(dv3), .deq_ready(deq_ready), .deq_data(dd3),
        .grant_idx(gi3), .grant_active(ga3)
    );

    task automatic cmp(input string tag, input gpreg_t obs, input gpreg_t expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_data(input gpreg_t b);
        base = b;
        for (int i = 0; i < 4; i++) req_data[i] = b + gpreg_t'(i);
    endtask

    task automatic push(input string tag, input int d, input logic v, input arb_idx_t idx, input logic r);
        exp_t e;
        e.tag  = tag;
        e.d    = d;
        e.v    = v;
        e.idx  = idx;
        e.rdy  = (v && r) ? 4'(1 << idx) : 4'b0;
        e.data = base + gpreg_t'(idx);
        sbq.push_back(e);
    endtask

    task automatic push2(input string tag, input arb_idx_t i1, input arb_idx_t i3);
        push(tag, 1, 1'b1, i1, deq_ready);
        push(tag, 3, 1'b1, i3, deq_ready);
    endtask

    task automatic check_now();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            cmp({e.tag, ".valid"}, gpreg_t'(e.d == 1 ? dv1 : dv3), gpreg_t'(e.v));
            cmp({e.tag, ".active"}, gpreg_t'(e.d == 1 ? ga1 : ga3), gpreg_t'(e.v));
            cmp({e.tag, ".idx"}, gpreg_t'(e.d == 1 ? gi1 : gi3), gpreg_t'(e.idx));
            cmp({e.tag, ".ready"}, gpreg_t'(e.d == 1 ? rdy1 : rdy3), gpreg_t'(e.rdy));
            if (e.v) cmp({e.tag, ".data"}, e.d == 1 ? dd1 : dd3, e.data);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        deq_ready = 1'b0;
        req_valid = 4'b0;
        set_data(64'h100);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        push("idle", 1, 1'b0, 2'd0, 1'b0);
        push("idle", 3, 1'b0, 2'd0, 1'b0);
        cyc();

        set_data(64'h200);
        req_valid = 4'hf;
        deq_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            push2("rr", 2'(c % 4), 2'((c / 3) % 4));
            cyc();
        end

        do_reset();
        set_data(64'h300);
        for (int c = 0; c < 12; c++) begin
            deq_ready = (c % 2 == 0);
            push2("toggle", 2'(((c + 1) / 2) % 4), 2'(((c + 1) / 6) % 4));
            cyc();
        end

        do_reset();
        set_data(64'h400);
        req_valid = 4'b0001;
        deq_ready = 1'b1;
        push2("lock_pre", 2'd0, 2'd0);
        cyc();
        req_valid = 4'b0110;
        deq_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            push2("lock_hold", 2'd1, 2'd1);
            cyc();
        end
        req_valid = 4'b0111;
        push2("lock_r0", 2'd1, 2'd1);
        cyc();
        deq_ready = 1'b1;
        push2("lock_xfer", 2'd1, 2'd1);
        cyc();
        push2("lock_next", 2'd2, 2'd1);
        cyc();

        do_reset();
        set_data(64'h500);
        deq_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            req_valid = (c % 2 == 0) ? 4'b1000 : 4'b0001;
            push2("sparse", (c % 2 == 0) ? 2'd3 : 2'd0, (c % 2 == 0) ? 2'd3 : 2'd0);
            cyc();
        end

        do_reset();
        set_data(64'h600);
        req_valid = 4'b0100;
        deq_ready = 1'b1;
        push2("flush_pre", 2'd2, 2'd2);
        cyc();
        req_valid = 4'hf;
        deq_ready = 1'b0;
        push2("flush_lock", 2'd3, 2'd2);
        cyc();
        flush = 1'b1;
        push2("flush_cyc", 2'd3, 2'd2);
        cyc();
        flush = 1'b0;
        deq_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            push2("flush_post", 2'(c), (c < 3) ? 2'd0 : 2'd1);
            cyc();
        end

        do_reset();
        set_data(64'h700);
        req_valid = 4'hf;
        deq_ready = 1'b1;
        push2("areset_pre", 2'd0, 2'd0);
        cyc();
        deq_ready = 1'b0;
        push2("areset_stall", 2'd1, 2'd0);
        cyc();
        rst = 1'b1;
        #1;
        push2("areset_now", 2'd0, 2'd0);
        check_now();
        @(posedge clk);
        #1 rst = 1'b0;
        push2("areset_after", 2'd0, 2'd0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
